// File: rtl/fetch_pair_queue_if.sv
// IF/ID pair bus: fetch bundle in, two oldest queued instructions out, ID consume/redirect back.
interface fetch_pair_queue_if #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ID_W  = 8
);
   logic                     fetch_valid;
   logic [1:0]               fetch_cnt;
   logic [31:0]              fetch_pc;
   logic [31:0]              fetch_instr0;
   logic [31:0]              fetch_instr1;
   logic                     fetch_ready;
   logic                     out_valid0;
   logic                     out_valid1;
   logic [31:0]              out_pc0;
   logic [31:0]              out_pc1;
   logic [31:0]              out_instr0;
   logic [31:0]              out_instr1;
   logic [ID_W-1:0]          out_id0;
   logic [ID_W-1:0]          out_id1;
   logic [1:0]               consume;
   logic                     redirect;
   logic [$clog2(DEPTH):0]   occupancy;

   // Driver side: fetch unit plus ID stage.
   modport master (
      output fetch_valid, fetch_cnt, fetch_pc, fetch_instr0, fetch_instr1, consume, redirect,
      input  fetch_ready, out_valid0, out_valid1, out_pc0, out_pc1, out_instr0, out_instr1,
             out_id0, out_id1, occupancy
   );

   modport slave (
      input  fetch_valid, fetch_cnt, fetch_pc, fetch_instr0, fetch_instr1, consume, redirect,
      output fetch_ready, out_valid0, out_valid1, out_pc0, out_pc1, out_instr0, out_instr1,
             out_id0, out_id1, occupancy
   );
endinterface

// File: rtl/fetch_pair_queue.sv
// Dual-issue fetch queue feeding ID with the two oldest instructions.
// Optional same-cycle bypass into an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_pair_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ID_W  = 8
) (
   input logic             clk,
   input logic             rst,
   fetch_pair_queue_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   ptr_t            head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
   cnt_t            count_q, count_d, avail;
   logic [ID_W-1:0] id_ctr_q, id_ctr_d;
   logic [31:0]     pc_q    [DEPTH];
   logic [31:0]     pc_d    [DEPTH];
   logic [31:0]     instr_q [DEPTH];
   logic [31:0]     instr_d [DEPTH];
   logic [ID_W-1:0] id_q    [DEPTH];
   logic [ID_W-1:0] id_d    [DEPTH];

   logic       fetch_ready, cnt_ok, push, bypass;
   logic [1:0] push_cnt, cons, pop_cnt;

   always_comb begin
      head_p1     = head_q + ptr_t'(1);
      tail_p1     = tail_q + ptr_t'(1);
      // Ready comes only from registered count so consume never reaches it combinationally.
      fetch_ready = (count_q <= cnt_t'(DEPTH - 2));
      cnt_ok      = (bus.fetch_cnt == 2'd1) || (bus.fetch_cnt == 2'd2);
      push        = bus.fetch_valid && fetch_ready && cnt_ok && !bus.redirect;
      push_cnt    = push ? bus.fetch_cnt : 2'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass      = push && (count_q == '0);
`else
      bypass      = 1'b0;
`endif
      // A bypassed bundle is written whole and popped from head like any queued entry.
      avail       = bypass ? cnt_t'(push_cnt) : count_q;
      cons        = (bus.consume > 2'd2) ? 2'd2 : bus.consume;
      pop_cnt     = (cnt_t'(cons) > avail) ? avail[1:0] : cons;
   end

   always_comb begin
      bus.fetch_ready = fetch_ready;
      bus.occupancy   = count_q;
      bus.out_valid0  = (avail >= cnt_t'(1));
      bus.out_valid1  = (avail >= cnt_t'(2));
      bus.out_pc0     = '0;
      bus.out_instr0  = '0;
      bus.out_id0     = '0;
      bus.out_pc1     = '0;
      bus.out_instr1  = '0;
      bus.out_id1     = '0;
      if (bypass) begin
         bus.out_pc0    = bus.fetch_pc;
         bus.out_instr0 = bus.fetch_instr0;
         bus.out_id0    = id_ctr_q;
         if (bus.out_valid1) begin
            bus.out_pc1    = bus.fetch_pc + 32'd4;
            bus.out_instr1 = bus.fetch_instr1;
            bus.out_id1    = id_ctr_q + ID_W'(1);
         end
      end else begin
         if (bus.out_valid0) begin
            bus.out_pc0    = pc_q[head_q];
            bus.out_instr0 = instr_q[head_q];
            bus.out_id0    = id_q[head_q];
         end
         if (bus.out_valid1) begin
            bus.out_pc1    = pc_q[head_p1];
            bus.out_instr1 = instr_q[head_p1];
            bus.out_id1    = id_q[head_p1];
         end
      end
   end

   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      id_d     = id_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      id_ctr_d = id_ctr_q + ID_W'(push_cnt);
      if (push) begin
         pc_d[tail_q]    = bus.fetch_pc;
         instr_d[tail_q] = bus.fetch_instr0;
         id_d[tail_q]    = id_ctr_q;
         if (push_cnt == 2'd2) begin
            pc_d[tail_p1]    = bus.fetch_pc + 32'd4;
            instr_d[tail_p1] = bus.fetch_instr1;
            id_d[tail_p1]    = id_ctr_q + ID_W'(1);
         end
      end
      if (bus.redirect) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + ptr_t'(pop_cnt);
         tail_d  = tail_q + ptr_t'(push_cnt);
         count_d = count_q + cnt_t'(push_cnt) - cnt_t'(pop_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         id_ctr_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         id_ctr_q <= id_ctr_d;
      end
   end

   // Entry storage needs no reset: invalid slots are gated to zero at the outputs.
   always_ff @(posedge clk) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      id_q    <= id_d;
   end

   consume_le_avail_a : assert property (@(posedge clk) disable iff (rst)
      bus.redirect || (cnt_t'(bus.consume) <= avail));
endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue: reset, ordering, full, redirect, wrap and optional bypass.
module tb_fetch_pair_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fetch_pair_queue_if #(.DEPTH(8), .ID_W(8)) bus ();

   fetch_pair_queue #(.DEPTH(8), .ID_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.fetch_valid  = 1'b0;
      bus.fetch_cnt    = 2'd0;
      bus.fetch_pc     = '0;
      bus.fetch_instr0 = '0;
      bus.fetch_instr1 = '0;
      bus.consume      = 2'd0;
      bus.redirect     = 1'b0;
   endtask

   task automatic push(input logic [1:0] cnt, input logic [31:0] pc, input logic [1:0] cons);
      bus.fetch_valid  = 1'b1;
      bus.fetch_cnt    = cnt;
      bus.fetch_pc     = pc;
      bus.fetch_instr0 = pc ^ 32'hA5A5_0000;
      bus.fetch_instr1 = (pc + 32'd4) ^ 32'hA5A5_0000;
      bus.consume      = cons;
      bus.redirect     = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_pc;
   logic [7:0]  exp_id;

   initial begin
      idle();
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_valid0", 32'(bus.out_valid0), 32'd0);
      check_eq("rst_valid1", 32'(bus.out_valid1), 32'd0);
      check_eq("rst_ready", 32'(bus.fetch_ready), 32'd1);
      check_eq("rst_occ", 32'(bus.occupancy), 32'd0);
      check_eq("rst_pc0", bus.out_pc0, 32'd0);

      // First bundle: visible the cycle after the push edge.
      cyc();
      push(2'd2, 32'h1000, 2'd0);
      @(negedge clk);
`ifndef FETCH_QUEUE_BYPASS_EN
      check_eq("push_cycle_valid0", 32'(bus.out_valid0), 32'd0);
`endif
      cyc();
      idle();
      @(negedge clk);
      check_eq("first_valid0", 32'(bus.out_valid0), 32'd1);
      check_eq("first_valid1", 32'(bus.out_valid1), 32'd1);
      check_eq("first_pc0", bus.out_pc0, 32'h1000);
      check_eq("first_pc1", bus.out_pc1, 32'h1004);
      check_eq("first_id0", 32'(bus.out_id0), 32'd0);
      check_eq("first_id1", 32'(bus.out_id1), 32'd1);
      check_eq("first_instr0", bus.out_instr0, 32'h1000 ^ 32'hA5A5_0000);
      check_eq("first_instr1", bus.out_instr1, 32'h1004 ^ 32'hA5A5_0000);

      // Single-issue with simultaneous push keeps slot 1 and ids contiguous.
      cyc();
      push(2'd1, 32'h1008, 2'd0);
      cyc();
      push(2'd2, 32'h100C, 2'd1);
      @(negedge clk);
      check_eq("three_occ", 32'(bus.occupancy), 32'd3);
      cyc();
      idle();
      @(negedge clk);
      check_eq("mix_occ", 32'(bus.occupancy), 32'd4);
      check_eq("mix_pc0", bus.out_pc0, 32'h1004);
      check_eq("mix_id0", 32'(bus.out_id0), 32'd1);
      check_eq("mix_pc1", bus.out_pc1, 32'h1008);
      check_eq("mix_id1", 32'(bus.out_id1), 32'd2);

      // Fill to 7: a 1-instr bundle is refused too.
      cyc();
      push(2'd2, 32'h1014, 2'd0);
      cyc();
      idle();
      @(negedge clk);
      check_eq("six_occ", 32'(bus.occupancy), 32'd6);
      check_eq("six_ready", 32'(bus.fetch_ready), 32'd1);
      cyc();
      push(2'd1, 32'h101C, 2'd0);
      cyc();
      push(2'd1, 32'h2000, 2'd0);
      @(negedge clk);
      check_eq("seven_occ", 32'(bus.occupancy), 32'd7);
      check_eq("seven_ready", 32'(bus.fetch_ready), 32'd0);
      cyc();
      idle();
      bus.consume = 2'd2;
      @(negedge clk);
      check_eq("refused_occ", 32'(bus.occupancy), 32'd7);
      check_eq("ready_still_low", 32'(bus.fetch_ready), 32'd0);
      cyc();
      idle();
      @(negedge clk);
      check_eq("drain_occ", 32'(bus.occupancy), 32'd5);
      check_eq("drain_ready", 32'(bus.fetch_ready), 32'd1);
      check_eq("drain_pc0", bus.out_pc0, 32'h100C);
      check_eq("drain_id0", 32'(bus.out_id0), 32'd3);

      // Redirect flushes queue; same-cycle push ignored; id counter keeps running.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      push(2'd2, 32'h3000, 2'd0);
      cyc();
      push(2'd2, 32'h3008, 2'd0);
      cyc();
      push(2'd2, 32'h4000, 2'd2);
      bus.redirect = 1'b1;
      cyc();
      idle();
      @(negedge clk);
      check_eq("redir_occ", 32'(bus.occupancy), 32'd0);
      check_eq("redir_valid0", 32'(bus.out_valid0), 32'd0);
      check_eq("redir_pc0", bus.out_pc0, 32'd0);
      push(2'd1, 32'h5000, 2'd0);
      cyc();
      idle();
      @(negedge clk);
      check_eq("post_redir_pc0", bus.out_pc0, 32'h5000);
      check_eq("post_redir_id0", 32'(bus.out_id0), 32'd4);

      // Reset mid-operation restarts ids at 0.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_occ", 32'(bus.occupancy), 32'd0);
      check_eq("midrst_valid0", 32'(bus.out_valid0), 32'd0);
      push(2'd1, 32'h6000, 2'd0);
      cyc();
      idle();
      @(negedge clk);
      check_eq("midrst_id0", 32'(bus.out_id0), 32'd0);

      // Steady push 2 / consume 2: pointers wrap every 4 cycles, ids wrap past 255.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      push(2'd2, 32'h8000, 2'd0);
      cyc();
      exp_pc = 32'h8000;
      exp_id = 8'd0;
      for (int k = 0; k < 140; k++) begin
         push(2'd2, 32'h8008 + 32'(8 * k), 2'd2);
         @(negedge clk);
         check_eq("wrap_pc0", bus.out_pc0, exp_pc);
         check_eq("wrap_id0", 32'(bus.out_id0), 32'(exp_id));
         check_eq("wrap_id1", 32'(bus.out_id1), 32'(exp_id + 8'd1));
         cyc();
         exp_pc = exp_pc + 32'd8;
         exp_id = exp_id + 8'd2;
      end
      idle();
      @(negedge clk);
      check_eq("wrap_occ", 32'(bus.occupancy), 32'd2);

`ifdef FETCH_QUEUE_BYPASS_EN
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      push(2'd2, 32'h9000, 2'd1);
      @(negedge clk);
      check_eq("byp_valid0", 32'(bus.out_valid0), 32'd1);
      check_eq("byp_valid1", 32'(bus.out_valid1), 32'd1);
      check_eq("byp_pc0", bus.out_pc0, 32'h9000);
      check_eq("byp_pc1", bus.out_pc1, 32'h9004);
      check_eq("byp_id0", 32'(bus.out_id0), 32'd0);
      cyc();
      idle();
      @(negedge clk);
      check_eq("byp_occ", 32'(bus.occupancy), 32'd1);
      check_eq("byp_left_pc0", bus.out_pc0, 32'h9004);
      check_eq("byp_left_id0", 32'(bus.out_id0), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
